// File: rtl/usbdev_aon_wake_seq.sv
// usbdev_aon_wake_seq: always-on hand-over sequencer between USB device software
// and the AON wake detector. Enters suspend (ENTER), waits for the detector to
// take control (ARMED), latches the wake cause (WAKE), and hands control back
// (EXIT). ENTER and EXIT are bounded by a timeout that aborts back to IDLE.
//
// Handshake: the software inputs are single-cycle pulses that are either
// accepted by the current state or reported through a one-cycle req_ignored_o
// pulse. The detector side uses levels: suspend_req_aon_o is high for the whole
// ENTER state and wake_ack_aon_o is high for the whole EXIT state.
module usbdev_aon_wake_seq #(
    parameter int unsigned TimeoutCycles = 8
) (
    input  logic       clk_aon_i,
    input  logic       rst_aon_ni,
    input  logic       sw_suspend_req_i,
    input  logic       sw_wake_ack_i,
    input  logic       wake_detect_active_i,
    input  logic       wake_req_i,
    input  logic       bus_not_idle_i,
    input  logic       bus_reset_i,
    input  logic       sense_lost_i,
    output logic       suspend_req_aon_o,
    output logic       wake_ack_aon_o,
    output logic       evt_valid_o,
    output logic [2:0] evt_cause_o,
    output logic       timeout_o,
    output logic       req_ignored_o,
    output logic [2:0] state_o
);

    localparam int TW = $clog2(TimeoutCycles + 1);
    localparam logic [TW-1:0] TimerLast = TW'(TimeoutCycles - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ENTER = 3'd1,
        ST_ARMED = 3'd2,
        ST_WAKE  = 3'd3,
        ST_EXIT  = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            evt_valid_q, evt_valid_d;
    logic [2:0]      evt_cause_q, evt_cause_d;
    logic            timeout_q, timeout_d;
    logic            ignored_q, ignored_d;
    logic [2:0]      evt_in;

    assign evt_in = {sense_lost_i, bus_reset_i, bus_not_idle_i};

    // Next-state, timer and latched-event logic; all outputs come from the flops below.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        evt_valid_d = evt_valid_q;
        evt_cause_d = evt_cause_q;
        timeout_d   = timeout_q;
        ignored_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sw_wake_ack_i) ignored_d = 1'b1;
                if (sw_suspend_req_i) begin
                    state_d     = ST_ENTER;
                    evt_valid_d = 1'b0;
                    evt_cause_d = 3'b000;
                    timeout_d   = 1'b0;
                end
            end
            ST_ENTER: begin
                if (sw_suspend_req_i || sw_wake_ack_i) ignored_d = 1'b1;
                if (wake_detect_active_i) begin
                    state_d = ST_ARMED;
                end else if (timer_q == TimerLast) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_ARMED: begin
                if (sw_suspend_req_i) ignored_d = 1'b1;
                // Losing the detector wins over everything else in ARMED.
                if (!wake_detect_active_i) begin
                    state_d = ST_IDLE;
                end else if (wake_req_i) begin
                    evt_valid_d = 1'b1;
                    evt_cause_d = evt_in;
                    state_d     = sw_wake_ack_i ? ST_EXIT : ST_WAKE;
                end else if (sw_wake_ack_i) begin
                    state_d = ST_EXIT;
                end
            end
            ST_WAKE: begin
                if (sw_suspend_req_i) ignored_d = 1'b1;
                evt_cause_d = evt_cause_q | evt_in;
                if (!wake_detect_active_i) begin
                    state_d = ST_IDLE;
                end else if (sw_wake_ack_i) begin
                    state_d = ST_EXIT;
                end
            end
            ST_EXIT: begin
                if (sw_suspend_req_i || sw_wake_ack_i) ignored_d = 1'b1;
                if (!wake_detect_active_i) begin
                    state_d = ST_IDLE;
                end else if (timer_q == TimerLast) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Every state change restarts the dwell timer.
        if (state_d != state_q) timer_d = '0;
    end

    // State, timer and output registers with asynchronous clear.
    always_ff @(posedge clk_aon_i or negedge rst_aon_ni) begin
        if (!rst_aon_ni) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            evt_valid_q <= 1'b0;
            evt_cause_q <= 3'b000;
            timeout_q   <= 1'b0;
            ignored_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            evt_valid_q <= evt_valid_d;
            evt_cause_q <= evt_cause_d;
            timeout_q   <= timeout_d;
            ignored_q   <= ignored_d;
        end
    end

    assign suspend_req_aon_o = (state_q == ST_ENTER);
    assign wake_ack_aon_o    = (state_q == ST_EXIT);
    assign evt_valid_o       = evt_valid_q;
    assign evt_cause_o       = evt_cause_q;
    assign timeout_o         = timeout_q;
    assign req_ignored_o     = ignored_q;
    assign state_o           = state_q;

endmodule

// File: tb/tb_usbdev_aon_wake_seq.sv
// Directed bench for usbdev_aon_wake_seq: each vector drives one AON cycle of
// inputs and pushes the hand-computed output word expected after that edge;
// a monitor on the falling edge pops and compares.
module tb_usbdev_aon_wake_seq;

    logic       clk;
    logic       rst_n;
    logic       sus, ack, act, wreq, bni, brst, sl;
    logic       susp_o, wack_o, ev_o, to_o, ign_o;
    logic [2:0] cause_o, state_o;

    // Observed word: {state[2:0], suspend, wake_ack, evt_valid, cause[2:0], timeout, ignored}
    logic [10:0] exp_q[$];
    logic [10:0] obs;
    int          n_vec = 0;
    int          n_err = 0;
    int          vec_id = 0;

    usbdev_aon_wake_seq #(.TimeoutCycles(8)) dut (
        .clk_aon_i            (clk),
        .rst_aon_ni           (rst_n),
        .sw_suspend_req_i     (sus),
        .sw_wake_ack_i        (ack),
        .wake_detect_active_i (act),
        .wake_req_i           (wreq),
        .bus_not_idle_i       (bni),
        .bus_reset_i          (brst),
        .sense_lost_i         (sl),
        .suspend_req_aon_o    (susp_o),
        .wake_ack_aon_o       (wack_o),
        .evt_valid_o          (ev_o),
        .evt_cause_o          (cause_o),
        .timeout_o            (to_o),
        .req_ignored_o        (ign_o),
        .state_o              (state_o)
    );

    assign obs = {state_o, susp_o, wack_o, ev_o, cause_o, to_o, ign_o};

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [10:0] mk(input logic [2:0] st, input logic su, input logic wa,
                                       input logic ev, input logic [2:0] ca,
                                       input logic to, input logic ig);
        return {st, su, wa, ev, ca, to, ig};
    endfunction

    task automatic chk(input string name, input logic [10:0] got, input logic [10:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got st=%0d su=%b wa=%b ev=%b ca=%b to=%b ig=%b, want st=%0d su=%b wa=%b ev=%b ca=%b to=%b ig=%b",
                     name, got[10:8], got[7], got[6], got[5], got[4:2], got[1], got[0],
                     want[10:8], want[7], want[6], want[5], want[4:2], want[1], want[0]);
        end
    endtask

    // Driver: inputs {sus, ack, act, wreq, bni, brst, sl} for one cycle, expectation after the edge.
    task automatic step(input logic [6:0] in, input logic [10:0] want);
        @(negedge clk);
        {sus, ack, act, wreq, bni, brst, sl} = in;
        @(posedge clk);
        #1;
        exp_q.push_back(want);
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rst_n && exp_q.size() > 0) begin
            logic [10:0] w;
            w = exp_q.pop_front();
            vec_id++;
            chk($sformatf("vec%0d", vec_id), obs, w);
        end
    end

    initial begin
        {sus, ack, act, wreq, bni, brst, sl} = 7'b0;
        rst_n = 1'b0;
        #12;
        chk("reset_state", obs, 11'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Normal suspend / wake on bus reset / software resume
        step(7'b1000000, mk(1, 1, 0, 0, 3'b000, 0, 0));
        step(7'b0100000, mk(1, 1, 0, 0, 3'b000, 0, 1)); // ack in ENTER ignored
        step(7'b0000000, mk(1, 1, 0, 0, 3'b000, 0, 0));
        step(7'b0010000, mk(2, 0, 0, 0, 3'b000, 0, 0));
        step(7'b0011010, mk(3, 0, 0, 1, 3'b010, 0, 0));
        step(7'b0010000, mk(3, 0, 0, 1, 3'b010, 0, 0));
        step(7'b0010100, mk(3, 0, 0, 1, 3'b011, 0, 0)); // cause accumulates
        step(7'b0110000, mk(4, 0, 1, 1, 3'b011, 0, 0));
        step(7'b0010000, mk(4, 0, 1, 1, 3'b011, 0, 0));
        step(7'b0000000, mk(0, 0, 0, 1, 3'b011, 0, 0));
        step(7'b0100000, mk(0, 0, 0, 1, 3'b011, 0, 1)); // ack in IDLE ignored
        step(7'b0000000, mk(0, 0, 0, 1, 3'b011, 0, 0));

        // ENTER timeout: suspend high exactly 8 cycles
        step(7'b1000000, mk(1, 1, 0, 0, 3'b000, 0, 0));
        for (int i = 0; i < 7; i++) step(7'b0000000, mk(1, 1, 0, 0, 3'b000, 0, 0));
        step(7'b0000000, mk(0, 0, 0, 0, 3'b000, 1, 0));
        step(7'b0000000, mk(0, 0, 0, 0, 3'b000, 1, 0));
        step(7'b1000000, mk(1, 1, 0, 0, 3'b000, 0, 0)); // timeout cleared

        // ARMED: ignored suspend, then simultaneous wake_req + ack
        step(7'b0010000, mk(2, 0, 0, 0, 3'b000, 0, 0));
        step(7'b1010000, mk(2, 0, 0, 0, 3'b000, 0, 1));
        step(7'b0010000, mk(2, 0, 0, 0, 3'b000, 0, 0));
        step(7'b0111001, mk(4, 0, 1, 1, 3'b100, 0, 0));
        step(7'b0110000, mk(4, 0, 1, 1, 3'b100, 0, 1)); // ack in EXIT ignored
        for (int i = 0; i < 6; i++) step(7'b0010000, mk(4, 0, 1, 1, 3'b100, 0, 0));
        step(7'b0010000, mk(0, 0, 0, 1, 3'b100, 1, 0)); // EXIT timeout

        // Both pulses in IDLE; then detector loses control in WAKE
        step(7'b1100000, mk(1, 1, 0, 0, 3'b000, 0, 1));
        step(7'b0010000, mk(2, 0, 0, 0, 3'b000, 0, 0));
        step(7'b0011100, mk(3, 0, 0, 1, 3'b001, 0, 0));
        step(7'b0000000, mk(0, 0, 0, 1, 3'b001, 0, 0));

        // Into EXIT, then asynchronous reset
        step(7'b1000000, mk(1, 1, 0, 0, 3'b000, 0, 0));
        step(7'b0010000, mk(2, 0, 0, 0, 3'b000, 0, 0));
        step(7'b0110000, mk(4, 0, 1, 0, 3'b000, 0, 0));
        @(negedge clk);
        #1;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_mid_exit", obs, 11'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/usbdev_aon_wake_seq.md
USBDEV_AON_WAKE_SEQ -- requirements
Module: usbdev_aon_wake_seq

Interface
REQ-001 Parameter TimeoutCycles, default 8 (range 2..255), is the maximum AON cycles spent in ENTER or EXIT before abort.
REQ-002 clk_aon_i  input  1  AON clock; the only clock.
REQ-003 rst_aon_ni  input  1  asynchronous active-low reset.
REQ-004 sw_suspend_req_i  input  1  single-cycle pulse, already in AON domain: software requests hand-over to the wake detector.
REQ-005 sw_wake_ack_i  input  1  single-cycle pulse, already in AON domain: software acknowledges wake / requests resume.
REQ-006 wake_detect_active_i  input  1  detector's active state.
REQ-007 wake_req_i, bus_not_idle_i, bus_reset_i, sense_lost_i  input  1 each  detector wake request and sticky event flags.
REQ-008 suspend_req_aon_o  output  1  level suspend request to detector.
REQ-009 wake_ack_aon_o  output  1  level wake acknowledge to detector.
REQ-010 evt_valid_o  output  1  a wake cause is latched.
REQ-011 evt_cause_o  output  3  latched cause {sense_lost, bus_reset, bus_not_idle}.
REQ-012 timeout_o  output  1  sticky: last ENTER or EXIT aborted on timeout.
REQ-013 req_ignored_o  output  1  one-cycle pulse: a software pulse arrived in a state that does not accept it.
REQ-014 state_o  output  3  FSM state: IDLE=0, ENTER=1, ARMED=2, WAKE=3, EXIT=4.

Function
REQ-015 All outputs are driven from flops; no combinational input-to-output path.
REQ-016 suspend_req_aon_o is 1 exactly while in ENTER; wake_ack_aon_o is 1 exactly while in EXIT.
REQ-017 IDLE + sw_suspend_req_i -> ENTER next cycle; also clears evt_valid_o, evt_cause_o, timeout_o and zeroes the timer.
REQ-018 ENTER: wake_detect_active_i=1 -> ARMED; else timer increments; when timer reaches TimeoutCycles-1 with active still 0 -> IDLE and timeout_o=1 (suspend_req_aon_o high exactly TimeoutCycles cycles).
REQ-019 ARMED: wake_req_i=1 -> WAKE; evt_cause_o loads {sense_lost_i, bus_reset_i, bus_not_idle_i}; evt_valid_o=1 same edge.
REQ-020 ARMED: sw_wake_ack_i=1 with wake_req_i=0 -> EXIT (software resume); evt_valid_o stays 0.
REQ-021 ARMED: wake_req_i and sw_wake_ack_i in same cycle -> cause latched per REQ-019 and direct transition to EXIT.
REQ-022 WAKE: evt_cause_o bits OR-accumulate each cycle with the event inputs; sw_wake_ack_i -> EXIT.
REQ-023 ARMED or WAKE with wake_detect_active_i=0 (detector lost control) -> IDLE, evt_valid_o unchanged.
REQ-024 EXIT: wake_detect_active_i=0 -> IDLE; else timer increments; at TimeoutCycles-1 -> IDLE with timeout_o=1.
REQ-025 Timer zeroes on every state change; width is clog2(TimeoutCycles+1); it never wraps.
REQ-026 sw_suspend_req_i outside IDLE, or sw_wake_ack_i in IDLE/ENTER/EXIT: no state effect, req_ignored_o=1 next cycle.
REQ-027 Both software pulses in the same cycle: each is evaluated independently per REQ-017..026 against the current state (the one not accepted flags req_ignored_o).
REQ-028 evt_valid_o/evt_cause_o hold through EXIT and IDLE until the next accepted sw_suspend_req_i.
REQ-029 Unused state encodings -> IDLE next cycle with outputs as IDLE.

Reset
REQ-030 Reset asserted (any time, including mid-ENTER/EXIT): state IDLE, timer 0, all outputs 0 immediately.
REQ-031 First accepted transition occurs on the first clock edge after reset release.

Verification
REQ-032 Suspend, active after 3 cycles, wake_req with bus_reset=1 -> state 1,2,3; evt_cause_o=3'b010, evt_valid_o=1; sw_wake_ack -> EXIT; active drops -> IDLE, suspend_req_aon_o high 3 cycles.
REQ-033 Suspend with active held 0, TimeoutCycles=8 -> suspend_req_aon_o high 8 cycles, IDLE, timeout_o=1; next sw_suspend_req clears timeout_o.
REQ-034 ARMED, wake_req and sw_wake_ack same cycle, sense_lost=1 -> ENTER...EXIT directly, evt_cause_o=3'b100.
REQ-035 sw_wake_ack in IDLE and sw_suspend_req in ARMED -> req_ignored_o one-cycle pulse each, state unchanged.
REQ-036 Reset asserted mid-EXIT -> wake_ack_aon_o, state_o, evt_valid_o all 0 without a clock edge.
